// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates ICache fetches and LSB loads/stores onto a byte-wide RAM/IO bus.
// Read of n bytes: valid in cycle n+2. Store: valid in cycle n+1 plus one cycle per IO stall. rdy low freezes all state.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        ic_enable,
    input  logic [31:0] ic_addr,
    output logic        ic_valid,
    output logic [31:0] ic_data,
    input  logic        lsb_enable,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_data,
    output logic        lsb_valid,
    output logic [31:0] lsb_result,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef enum logic {OWN_IC, OWN_LSB} owner_t;

    state_t      state;
    owner_t      owner;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic [2:0]  k;          // read: next byte to address; write: byte currently on the bus
    logic [1:0]  c;          // next read byte to capture
    logic [1:0]  n_m1;       // byte count minus one
    logic        rd_pend;    // an address of ours was driven last cycle
    logic        mem_wr_reg;

    logic [1:0]  lsb_n_m1;
    logic        accept_stall;
    logic        wr_stall;
    logic [31:0] merged;
    logic [1:0]  k_next;

    function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] idx);
        case (idx)
            2'd0:    pick_byte = d[7:0];
            2'd1:    pick_byte = d[15:8];
            2'd2:    pick_byte = d[23:16];
            default: pick_byte = d[31:24];
        endcase
    endfunction

    always_comb begin
        lsb_n_m1 = 2'd3;
        case (lsb_len)
            2'd0:    lsb_n_m1 = 2'd0;
            2'd1:    lsb_n_m1 = 2'd1;
            default: lsb_n_m1 = 2'd3;
        endcase
    end

    // The IO window is base[17:16] == 2'b11; writes there wait for buffer space.
    assign accept_stall = (lsb_addr[17:16] == 2'b11) && io_buffer_full;
    assign wr_stall     = (base[17:16] == 2'b11) && io_buffer_full;
    assign merged       = rbuf | ({24'b0, mem_din} << {c, 3'b000});
    assign k_next       = k[1:0] + 2'd1;

    // Gating by rdy keeps a held write cycle from hitting the IO buffer twice.
    assign mem_wr = mem_wr_reg & rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IC;
            base       <= '0;
            wdata      <= '0;
            rbuf       <= '0;
            k          <= '0;
            c          <= '0;
            n_m1       <= '0;
            rd_pend    <= 1'b0;
            mem_wr_reg <= 1'b0;
            mem_a      <= '0;
            mem_dout   <= '0;
            ic_valid   <= 1'b0;
            ic_data    <= '0;
            lsb_valid  <= 1'b0;
            lsb_result <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    ic_valid   <= 1'b0;
                    lsb_valid  <= 1'b0;
                    mem_wr_reg <= 1'b0;
                    mem_a      <= '0;
                    rbuf       <= '0;
                    c          <= '0;
                    rd_pend    <= 1'b0;
                    if (!rollback && lsb_enable) begin
                        owner <= OWN_LSB;
                        base  <= lsb_addr;
                        wdata <= lsb_data;
                        n_m1  <= lsb_n_m1;
                        mem_a <= lsb_addr;
                        if (lsb_wr) begin
                            state      <= WRITE;
                            k          <= 3'd0;
                            mem_dout   <= lsb_data[7:0];
                            mem_wr_reg <= !accept_stall;
                        end else begin
                            state <= READ;
                            k     <= 3'd1;
                        end
                    end else if (!rollback && ic_enable) begin
                        owner <= OWN_IC;
                        base  <= ic_addr;
                        n_m1  <= 2'd3;
                        mem_a <= ic_addr;
                        state <= READ;
                        k     <= 3'd1;
                    end
                end
                READ: begin
                    if (rollback) begin
                        state   <= IDLE;
                        mem_a   <= '0;
                        rd_pend <= 1'b0;
                    end else begin
                        rd_pend <= 1'b1;
                        if (k <= {1'b0, n_m1}) begin
                            mem_a <= base + {29'b0, k};
                            k     <= k + 3'd1;
                        end else begin
                            mem_a <= '0;
                        end
                        if (rd_pend) begin
                            rbuf <= merged;
                            c    <= c + 2'd1;
                            if (c == n_m1) begin
                                state <= DONE;
                                if (owner == OWN_IC) begin
                                    ic_data  <= merged;
                                    ic_valid <= 1'b1;
                                end else begin
                                    lsb_result <= merged;
                                    lsb_valid  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                WRITE: begin
                    // Stores ignore rollback: they are already committed.
                    if (mem_wr_reg) begin
                        if (k[1:0] == n_m1) begin
                            state      <= DONE;
                            lsb_valid  <= 1'b1;
                            mem_wr_reg <= 1'b0;
                            mem_a      <= '0;
                        end else begin
                            k          <= {1'b0, k_next};
                            mem_a      <= base + {30'b0, k_next};
                            mem_dout   <= pick_byte(wdata, k_next);
                            mem_wr_reg <= !wr_stall;
                        end
                    end else begin
                        mem_wr_reg <= !wr_stall;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    ic_valid  <= 1'b0;
                    lsb_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM model, per-request scoreboard, write log.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        ic_enable;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic        lsb_enable, lsb_wr;
    logic [31:0] lsb_addr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_data;
    logic        lsb_valid;
    logic [31:0] lsb_result;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .ic_enable(ic_enable), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
        .lsb_enable(lsb_enable), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_data(lsb_data), .lsb_valid(lsb_valid), .lsb_result(lsb_result),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;
    typedef struct {
        bit          is_ic;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic [7:0]  ram [logic [31:0]];
    wr_t         wr_q[$];
    exp_t        sb[$];
    logic [31:0] a_log [0:15];
    int cyc = 0;
    int t0 = 0;
    int io_wr_cnt = 0;
    int ic_pulses = 0;
    int lsb_pulses = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // RAM answers the address of the previous cycle; writes land at the edge.
    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            ram[mem_a] = mem_dout;
            wr_q.push_back('{a: mem_a, d: mem_dout, c: cyc - t0});
            if (mem_a[17:16] == 2'b11) io_wr_cnt++;
        end
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc - t0 >= 0 && cyc - t0 < 16) a_log[cyc - t0] = mem_a;
        if (ic_valid === 1'b1) ic_pulses++;
        if (lsb_valid === 1'b1) lsb_pulses++;
    end

    // Begins cycle 0 of a new request just after the clock edge.
    task automatic start_cycle();
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    task automatic wait_valid(input bit want_ic, input int budget, output int lat,
                              output logic [31:0] d, output bit got);
        got = 1'b0;
        lat = -1;
        d   = '0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (want_ic ? ic_valid === 1'b1 : lsb_valid === 1'b1) begin
                got = 1'b1;
                lat = cyc - t0;
                d   = want_ic ? ic_data : lsb_result;
                if (want_ic) ic_enable = 1'b0;
                else lsb_enable = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        ic_enable = 1'b0; ic_addr = '0;
        lsb_enable = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ic_valid, lsb_valid, mem_wr} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000", {ic_valid, lsb_valid, mem_wr});
        end
        n_cmp++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_bus: mem_a=%h mem_dout=%h want 0", mem_a, mem_dout);
        end
        n_cmp++;
        if (ic_data !== 32'h0 || lsb_result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: ic_data=%h lsb_result=%h want 0", ic_data, lsb_result);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_ic_fetch();
        int lat; logic [31:0] d; bit got; exp_t e;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        start_cycle();
        ic_enable = 1'b1; ic_addr = 32'h100;
        sb.push_back('{is_ic: 1'b1, data: 32'h0000_0513, lat: 6});
        wait_valid(1'b1, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || d !== e.data || lat != e.lat) begin
            n_bad++;
            $display("FAIL ic_fetch: got=%0b data=%h lat=%0d want data=%h lat=%0d", got, d, lat, e.data, e.lat);
        end
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (a_log[i] !== 32'h100 + 32'(i - 1)) begin
                n_bad++;
                $display("FAIL ic_addr_seq cycle %0d: mem_a=%h want %h", i, a_log[i], 32'h100 + 32'(i - 1));
            end
        end
        @(negedge clk);
        n_cmp++;
        if (ic_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ic_valid_pulse: ic_valid=%b one cycle after, want 0", ic_valid);
        end
    endtask

    task automatic test_contention();
        int lat; logic [31:0] d; bit got; exp_t e; int snap;
        ram[32'h200] = 8'hFF;
        ram[32'h104] = 8'h93; ram[32'h105] = 8'h00; ram[32'h106] = 8'h10; ram[32'h107] = 8'h00;
        start_cycle();
        snap = ic_pulses;
        lsb_enable = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_len = 2'd0;
        ic_enable = 1'b1; ic_addr = 32'h104;
        sb.push_back('{is_ic: 1'b0, data: 32'h0000_00FF, lat: 3});
        sb.push_back('{is_ic: 1'b1, data: 32'h0010_0093, lat: 10});
        wait_valid(1'b0, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || d !== e.data || lat != e.lat) begin
            n_bad++;
            $display("FAIL contention_lsb: got=%0b data=%h lat=%0d want data=%h lat=%0d", got, d, lat, e.data, e.lat);
        end
        wait_valid(1'b1, 30, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || d !== e.data || lat != e.lat) begin
            n_bad++;
            $display("FAIL contention_ic: got=%0b data=%h lat=%0d want data=%h lat=%0d", got, d, lat, e.data, e.lat);
        end
        #1;
        n_cmp++;
        if (ic_pulses - snap != 1) begin
            n_bad++;
            $display("FAIL contention_ic_pulses: got %0d want 1", ic_pulses - snap);
        end
    endtask

    task automatic test_store_half();
        int lat; logic [31:0] d; bit got; exp_t e;
        wr_q.delete();
        start_cycle();
        lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h300; lsb_len = 2'd1; lsb_data = 32'h0000_ABCD;
        sb.push_back('{is_ic: 1'b0, data: 32'h0, lat: 3});
        wait_valid(1'b0, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || lat != e.lat) begin
            n_bad++;
            $display("FAIL store_half_lat: got=%0b lat=%0d want %0d", got, lat, e.lat);
        end
        n_cmp++;
        if (wr_q.size() != 2) begin
            n_bad++;
            $display("FAIL store_half_count: %0d writes want 2", wr_q.size());
        end else begin
            n_cmp++;
            if (wr_q[0].a !== 32'h300 || wr_q[0].d !== 8'hCD || wr_q[1].a !== 32'h301 || wr_q[1].d !== 8'hAB) begin
                n_bad++;
                $display("FAIL store_half_bytes: (%h,%h) (%h,%h) want (300,cd) (301,ab)",
                         wr_q[0].a, wr_q[0].d, wr_q[1].a, wr_q[1].d);
            end
        end
    endtask

    task automatic test_io_stall();
        int lat; logic [31:0] d; bit got; exp_t e; int io0;
        wr_q.delete();
        io0 = io_wr_cnt;
        start_cycle();
        io_buffer_full = 1'b1;
        lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0003_0000; lsb_len = 2'd0; lsb_data = 32'h5A;
        sb.push_back('{is_ic: 1'b0, data: 32'h0, lat: 5});
        repeat (3) @(posedge clk);
        #1 io_buffer_full = 1'b0;
        wait_valid(1'b0, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || lat != e.lat) begin
            n_bad++;
            $display("FAIL io_stall_lat: got=%0b lat=%0d want %0d", got, lat, e.lat);
        end
        n_cmp++;
        if (io_wr_cnt - io0 != 1 || wr_q.size() != 1) begin
            n_bad++;
            $display("FAIL io_stall_count: io writes %0d want 1", io_wr_cnt - io0);
        end else begin
            n_cmp++;
            if (wr_q[0].c != 4 || wr_q[0].d !== 8'h5A) begin
                n_bad++;
                $display("FAIL io_stall_write: cycle %0d data %h want cycle 4 data 5a", wr_q[0].c, wr_q[0].d);
            end
        end
    endtask

    task automatic test_rollback();
        int lat; logic [31:0] d; bit got; exp_t e; int snap;
        start_cycle();
        snap = ic_pulses;
        ic_enable = 1'b1; ic_addr = 32'h100;
        repeat (3) @(posedge clk);
        #1 rollback = 1'b1;
        @(posedge clk);
        #1 rollback = 1'b0;
        ic_enable = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (ic_pulses != snap || mem_a !== 32'h0) begin
            n_bad++;
            $display("FAIL rollback_ic: pulses %0d mem_a %h want 0 pulses, mem_a 0", ic_pulses - snap, mem_a);
        end
        start_cycle();
        ic_enable = 1'b1; ic_addr = 32'h100;
        sb.push_back('{is_ic: 1'b1, data: 32'h0000_0513, lat: 6});
        wait_valid(1'b1, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || d !== e.data || lat != e.lat) begin
            n_bad++;
            $display("FAIL rollback_refetch: got=%0b data=%h lat=%0d want data=%h lat=%0d", got, d, lat, e.data, e.lat);
        end
        start_cycle();
        lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h400; lsb_len = 2'd2; lsb_data = 32'h1122_3344;
        sb.push_back('{is_ic: 1'b0, data: 32'h0, lat: 5});
        repeat (2) @(posedge clk);
        #1 rollback = 1'b1;
        @(posedge clk);
        #1 rollback = 1'b0;
        wait_valid(1'b0, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || lat != e.lat) begin
            n_bad++;
            $display("FAIL rollback_store_lat: got=%0b lat=%0d want %0d", got, lat, e.lat);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (ram[32'h400] !== 8'h44 || ram[32'h403] !== 8'h11) begin
            n_bad++;
            $display("FAIL rollback_store_ram: [400]=%h [403]=%h want 44 11", ram[32'h400], ram[32'h403]);
        end
    endtask

    task automatic test_rdy_stall();
        int lat; logic [31:0] d; bit got; exp_t e;
        logic [31:0] wd;
        int want_c [4];
        want_c = '{1, 4, 5, 6};
        wd = 32'hDEAD_BEEF;
        wr_q.delete();
        start_cycle();
        lsb_enable = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h500; lsb_len = 2'd2; lsb_data = wd;
        sb.push_back('{is_ic: 1'b0, data: 32'h0, lat: 7});
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
        wait_valid(1'b0, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || lat != e.lat) begin
            n_bad++;
            $display("FAIL rdy_store_lat: got=%0b lat=%0d want %0d", got, lat, e.lat);
        end
        n_cmp++;
        if (wr_q.size() != 4) begin
            n_bad++;
            $display("FAIL rdy_store_count: %0d writes want 4", wr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (wr_q[i].a !== 32'h500 + 32'(i) || wr_q[i].d !== wd[8*i +: 8] || wr_q[i].c != want_c[i]) begin
                    n_bad++;
                    $display("FAIL rdy_store_byte%0d: (%h,%h,c%0d) want (%h,%h,c%0d)", i, wr_q[i].a, wr_q[i].d,
                             wr_q[i].c, 32'h500 + 32'(i), wd[8*i +: 8], want_c[i]);
                end
            end
        end
    endtask

    task automatic test_rst_mid_read();
        int lat; logic [31:0] d; bit got; exp_t e; int snap;
        start_cycle();
        snap = ic_pulses;
        ic_enable = 1'b1; ic_addr = 32'h100;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ic_enable = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_a !== 32'h0 || ic_valid !== 1'b0 || ic_data !== 32'h0 || lsb_result !== 32'h0 || mem_wr !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_read: mem_a=%h ic_valid=%b ic_data=%h lsb_result=%h mem_wr=%b want all 0",
                     mem_a, ic_valid, ic_data, lsb_result, mem_wr);
        end
        repeat (8) @(negedge clk);
        #1;
        n_cmp++;
        if (ic_pulses != snap) begin
            n_bad++;
            $display("FAIL rst_no_valid: %0d pulses want 0", ic_pulses - snap);
        end
        start_cycle();
        ic_enable = 1'b1; ic_addr = 32'h104;
        sb.push_back('{is_ic: 1'b1, data: 32'h0010_0093, lat: 6});
        wait_valid(1'b1, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || d !== e.data || lat != e.lat) begin
            n_bad++;
            $display("FAIL rst_refetch: got=%0b data=%h lat=%0d want data=%h lat=%0d", got, d, lat, e.data, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] d; bit got; exp_t e;
        start_cycle();
        lsb_enable = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_len = 2'd1;
        sb.push_back('{is_ic: 1'b0, data: 32'h0000_0513, lat: 4});
        wait_valid(1'b0, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || d !== e.data || lat != e.lat) begin
            n_bad++;
            $display("FAIL b2b_first: got=%0b data=%h lat=%0d want data=%h lat=%0d", got, d, lat, e.data, e.lat);
        end
        // Next request raised in the IDLE cycle right after DONE; len 3 reads a word.
        start_cycle();
        lsb_enable = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h102; lsb_len = 2'd3;
        sb.push_back('{is_ic: 1'b0, data: 32'h0093_0000, lat: 6});
        wait_valid(1'b0, 20, lat, d, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || d !== e.data || lat != e.lat) begin
            n_bad++;
            $display("FAIL b2b_second: got=%0b data=%h lat=%0d want data=%h lat=%0d", got, d, lat, e.data, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_ic_fetch();
        test_contention();
        test_store_half();
        test_io_stall();
        test_rollback();
        test_rdy_stall();
        test_rst_mid_read();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
